// File: rtl/ureg_nbit.sv
// Universal N-bit register: hold/load/shift/rotate/inc/dec. Also has a burst
// shift/rotate sequencer with a busy/done handshake and status flags.
// All state changes on the falling edge of ck. rst_n is an async, active-low reset.
module ureg_nbit #(
    parameter int N   = 8,
    parameter int SHW = 3
) (
    input  logic           ck,
    input  logic           rst_n,
    input  logic           en,
    input  logic [2:0]     mode,
    input  logic [N-1:0]   d,
    input  logic           sin,
    input  logic           start,
    input  logic [SHW-1:0] amt,
    output logic [N-1:0]   q,
    output logic           sout,
    output logic           carry,
    output logic           zero,
    output logic           busy,
    output logic           done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROTL = 3'b100;
    localparam logic [2:0] M_ROTR = 3'b101;
    localparam logic [2:0] M_INC  = 3'b110;
    localparam logic [2:0] M_DEC  = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [2:0]     lmode_q, lmode_d;
    logic [N-1:0]   q_q, q_d;
    logic           sout_q, sout_d;
    logic           carry_q, carry_d;
    logic           done_q, done_d;

    // One datapath step is applied per edge when op_en is set, using op_mode.
    logic           op_en;
    logic [2:0]     op_mode;
    logic           burst_mode;

    // Modes 010..101 are exactly the shift/rotate modes a burst may use.
    assign burst_mode = mode[2] ^ mode[1];

    // State register: the FSM, the sequencer and the datapath all update on the falling edge.
    always_ff @(negedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lmode_q <= M_HOLD;
            q_q     <= '0;
            sout_q  <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lmode_q <= lmode_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: accept starts, count burst steps, choose the step to apply.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lmode_d = lmode_q;
        done_d  = 1'b0;
        op_en   = 1'b0;
        op_mode = M_HOLD;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // start takes priority over en. A non-shift mode is dropped silently.
                    if (burst_mode) begin
                        if (amt == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RUN;
                            cnt_d   = amt;
                            lmode_d = mode;
                        end
                    end
                end else if (en) begin
                    op_en   = 1'b1;
                    op_mode = mode;
                end
            end
            RUN: begin
                op_en   = 1'b1;
                op_mode = lmode_q;
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: compute one hold/load/shift/rotate/inc/dec step.
    always_comb begin
        q_d     = q_q;
        sout_d  = sout_q;
        carry_d = carry_q;
        if (op_en) begin
            case (op_mode)
                M_LOAD: q_d = d;
                M_SHL: begin
                    q_d    = {q_q[N-2:0], sin};
                    sout_d = q_q[N-1];
                end
                M_SHR: begin
                    q_d    = {sin, q_q[N-1:1]};
                    sout_d = q_q[0];
                end
                M_ROTL: begin
                    q_d    = {q_q[N-2:0], q_q[N-1]};
                    sout_d = q_q[N-1];
                end
                M_ROTR: begin
                    q_d    = {q_q[0], q_q[N-1:1]};
                    sout_d = q_q[0];
                end
                M_INC: {carry_d, q_d} = {1'b0, q_q} + (N+1)'(1);
                M_DEC: begin
                    q_d     = q_q - N'(1);
                    carry_d = (q_q == '0);
                end
                default: ;
            endcase
        end
    end

    // Outputs: the registered values, plus busy and zero decoded from state.
    always_comb begin
        q     = q_q;
        sout  = sout_q;
        carry = carry_q;
        done  = done_q;
        busy  = (state_q == RUN);
        zero  = (q_q == '0);
    end

endmodule

// File: doc/ureg_nbit.md
Name: ureg_nbit

Overview:
- Parametrised universal register, successor to the team's n-bit load register.
- Holds an N-bit value with hold, load, shift, rotate, increment and decrement modes.
- Adds a multi-cycle burst shift/rotate sequencer with a busy/done handshake, plus status flags.
- Sits in datapaths as an accumulator, shifter or counter register driven by a controller FSM.

Parameters:
- N, 8, data width in bits (N >= 2).
- SHW, 3, width of the burst-shift amount field; maximum burst length is 2^SHW - 1.

Ports:
- ck  input  1  clock; all state updates occur on the falling edge of ck.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  single-cycle operation enable.
- mode  input  3  operation select, encoding listed under Behaviour.
- d  input  N  parallel load data.
- sin  input  1  serial input bit for shl/shr.
- start  input  1  starts a burst of the shift/rotate mode given on mode.
- amt  input  SHW  burst length in steps, sampled with start.
- q  output  N  register contents.
- sout  output  1  bit shifted out by the most recent shift/rotate step.
- carry  output  1  carry (inc) or borrow (dec) from the most recent inc/dec.
- zero  output  1  combinational; 1 when q == 0.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse marking burst completion.

Behaviour:
- Reset: rst_n low forces q=0, sout=0, carry=0, busy=0, done=0 and FSM=IDLE immediately, independent of ck.
- Reset taken mid-burst aborts the burst; no done pulse is produced.
- Mode encoding (single step):
  - 000 hold
  - 001 load: q<=d
  - 010 shl: q<={q[N-2:0],sin}, sout<=q[N-1]
  - 011 shr: q<={sin,q[N-1:1]}, sout<=q[0]
  - 100 rotl: sout<=q[N-1]
  - 101 rotr: sout<=q[0]
  - 110 inc: {carry,q}<=q+1
  - 111 dec: q<=q-1, carry<=(q==0)
- carry changes only on inc/dec. sout changes only on shift/rotate steps. Wrap-around: inc of all-ones gives 0 with carry=1; dec of 0 gives all-ones with carry=1.
- IDLE state, start=0, en=1: perform the mode operation at the falling edge, one cycle latency.
- IDLE state, en=0: hold all state.
- IDLE state, start=1: overrides en.
  - start with mode 010..101: latch mode, latch amt into the step counter, go to RUN.
  - start with amt=0: stay IDLE and pulse done the next cycle; q is unchanged.
  - start with mode 000, 001, 110 or 111: ignored (no state change, no done).
- RUN state:
  - busy=1.
  - Each falling edge performs one step of the latched mode; shifts use the live sin each step.
  - The counter decrements each step. The edge that performs the final step returns the FSM to IDLE, drops busy and raises done for one cycle.
  - Total: amt steps over amt cycles, with busy high for exactly amt cycles.
- While busy: en, start, mode and amt are ignored; d is never loaded.
- done is registered and goes high in the cycle after the last step edge. A new start in that same cycle is accepted.
- zero is combinational on q and valid after reset (zero=1 out of reset).

Test Plan:
- Reset and load: reset -> q=0, zero=1. en=1, mode=001, d=8'hA5 -> q=A5 after one falling edge, zero=0. en=0 for 3 cycles -> q stays A5.
- Single steps from q=8'h81:
  - shl with sin=0 -> q=02, sout=1.
  - rotr -> q=01, sout=0.
  - shr with sin=1 -> q=80, sout=1.
- Counter wrap: load FF, inc -> q=00, carry=1, zero=1. Then dec -> q=FF, carry=1. Then dec -> q=FE, carry=0.
- Burst: load 8'h01, start with mode=100, amt=5 -> busy high for exactly 5 cycles, q=20, done pulses once, busy=0. A load requested during busy is ignored.
- Edge starts:
  - start with amt=0 -> no busy, done pulses once, q unchanged.
  - start with mode=110 -> no effect.
- Async reset mid-burst: start rotl with amt=7, assert rst_n low after 3 steps between clock edges -> q=0 and busy=0 immediately, no done pulse. After release, normal operation resumes.
